fb_sram_port: RTL and testbench
===============================

// Module: fb_sram_port
// PURPOSE
//  Single-port sequencer between the VGA scanout and the external async PSRAM framebuffer.
//  Serves one pixel read per slot from the timing generator and returns the byte on pixel.
//  Buffers pixel writes from the UART command decoder in a small FIFO.
//  Drains the FIFO to RAM only during blanking, so scanout reads are never delayed.
// PARAMETERS
//  ADDR_W       15  framebuffer byte address width; mem_adr = {(26-ADDR_W)'b0, addr}
//  ACC_CYC      4   clocks per RAM access (READ or WRITE); must be >= 3
//  FIFO_LOG2    3   write FIFO depth = 2**FIFO_LOG2 entries of {addr,data}
// PORTS
//  clk          in   1       system clock
//  reset_n      in   1       synchronous active-low reset
//  rd_req       in   1       one-cycle pulse: start pixel read at rd_addr
//  rd_addr      in   ADDR_W  pixel address, sampled with rd_req
//  blank        in   1       high = blanking interval, writes permitted
//  pixel        out  8       last read byte
//  pixel_valid  out  1       one-cycle pulse when pixel updates
//  wr_valid     in   1       write request from command decoder
//  wr_ready     out  1       FIFO can accept (= !full)
//  wr_addr      in   ADDR_W  write address
//  wr_data      in   8       write byte
//  fifo_level   out  FIFO_LOG2+1  current FIFO occupancy
//  err_ovf      out  1       sticky: wr_valid while !wr_ready
//  err_rdmiss   out  1       sticky: rd_req arrived during WRITE/TURN
//  mem_adr      out  26      RAM address
//  mem_db_out   out  16      write data {8'h00, byte}
//  mem_db_oe    out  1       top level drives MemDB when high
//  mem_db_in    in   16      RAM read data; low byte used
//  mem_oe_n, mem_we_n, ram_cs_n, ram_lb_n, ram_ub_n, ram_adv_n  out 1 each  RAM strobes
// BEHAVIOUR
//  Reset (reset_n low at edge): state IDLE, FIFO empty, pixel=0, pixel_valid=0, err_*=0,
//   mem_oe_n=mem_we_n=ram_cs_n=ram_ub_n=1, ram_lb_n=1, mem_db_oe=0, mem_adr=0. Applies mid-access;
//   in-flight write is abandoned (RAM content at that address undefined).
//  ram_adv_n=0 constant (async mode); ram_ub_n=1 constant; ram_lb_n=ram_cs_n.
//  FSM: IDLE, READ, WRITE, TURN. Access counter cnt counts 0..ACC_CYC-1.
//  IDLE: rd_req -> READ (priority). Else blank && !empty -> WRITE, pop head into addr/data regs.
//  READ: cs_n=0, oe_n=0, mem_adr=latched rd_addr, for ACC_CYC cycles. At edge ending cnt=ACC_CYC-1:
//   pixel<=mem_db_in[7:0], pixel_valid=1 next cycle. Latency: rd_req edge k -> pixel valid after k+ACC_CYC.
//   rd_req coincident with that final edge -> back-to-back READ, no idle gap. rd_req mid-READ: ignored, err_rdmiss=1.
//  WRITE: cs_n=0, mem_db_oe=1, data/addr stable all ACC_CYC cycles; we_n=0 only for cnt 1..ACC_CYC-2.
//   Then TURN (1 cycle, bus released, all strobes high) -> IDLE.
//  rd_req in WRITE/TURN: err_rdmiss=1, read dropped, pixel holds. Timing generator guarantees
//   blank falls >= ACC_CYC+2 cycles before first active rd_req; blank falling mid-WRITE completes it.
//  FIFO: push when wr_valid && wr_ready; push and pop same cycle legal at full or empty
//   (empty: no bypass, entry visible next cycle). Pointers wrap mod depth; level exact 0..depth.
//  wr_valid && !wr_ready: data dropped, err_ovf=1. err_* clear only on reset.
// CONFIGURATION
//  FB_WR_COALESCE_EN defined: wr_valid with wr_addr equal to the newest FIFO entry (entry not being
//   popped this cycle) overwrites that entry's data, no push; accepted even when full
//   (wr_ready = !full || match). Undefined: every accepted write pushes a new entry.
// TESTING
//  T1 reset: hold reset_n=0 during WRITE -> next edge all strobes high, mem_db_oe=0, level=0.
//  T2 read: ACC_CYC=4, mem_db_in=16'h00A5, rd_req@0 addr 0x1234 -> mem_adr=0x1234 cyc1-4, pixel=A5 pulse cyc5.
//  T3 back-to-back: rd_req every 4 cycles x160 -> 160 pixel_valid pulses, no idle cycle, err_rdmiss=0.
//  T4 drain: 3 writes while blank=0 -> level=3, no we_n; blank=1 -> 3 WRITE+TURN (5 cyc each), RAM holds data.
//  T5 overflow: 9 writes with blank=0, depth 8 -> wr_ready=0 after 8th, err_ovf=1, first 8 land in RAM.
//  T6 coalesce (macro on): write 0x10=11 then 0x10=22 -> level=1, RAM[0x10]=22; macro off -> level=2.

Source files
------------

// File: rtl/fb_sram_port.sv
// fb_sram_port: single-port sequencer between VGA scanout reads and the async
// PSRAM framebuffer. Pixel reads are served on demand; pixel writes are queued
// in a small FIFO and drained to RAM only while blank is high.
// Optional build macro FB_WR_COALESCE_EN: a write to the same address as the
// newest queued entry overwrites that entry instead of pushing a new one.
module fb_sram_port #(
  parameter int ADDR_W    = 15,
  parameter int ACC_CYC   = 4,
  parameter int FIFO_LOG2 = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rd_req,
  input  logic [ADDR_W-1:0]    rd_addr,
  input  logic                 blank,
  output logic [7:0]           pixel,
  output logic                 pixel_valid,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [7:0]           wr_data,
  output logic [FIFO_LOG2:0]   fifo_level,
  output logic                 err_ovf,
  output logic                 err_rdmiss,
  output logic [25:0]          mem_adr,
  output logic [15:0]          mem_db_out,
  output logic                 mem_db_oe,
  input  logic [15:0]          mem_db_in,
  output logic                 mem_oe_n,
  output logic                 mem_we_n,
  output logic                 ram_cs_n,
  output logic                 ram_lb_n,
  output logic                 ram_ub_n,
  output logic                 ram_adv_n
);
  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int CNT_W = $clog2(ACC_CYC);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_ent_t;

  typedef enum logic [1:0] {IDLE, READ, WRITE, TURN} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 last;
  wr_ent_t              fifo_mem [DEPTH];
  logic [FIFO_LOG2-1:0] wptr_q, rptr_q;
  logic [FIFO_LOG2:0]   level_q;
  logic                 empty, full, push, pop, upd, match, load_rd;
  logic [ADDR_W-1:0]    addr_q;
  logic [7:0]           data_q;
  logic                 unused_db_hi;

  assign unused_db_hi = ^mem_db_in[15:8];

  assign last    = (cnt_q == CNT_W'(ACC_CYC - 1));
  assign empty   = (level_q == '0);
  assign full    = (level_q == (FIFO_LOG2+1)'(DEPTH));
  // Reads always win; the FIFO drains only from IDLE during blanking.
  assign pop     = (state_q == IDLE) && !rd_req && blank && !empty;
  // A read request is accepted from IDLE or on the final edge of a read.
  assign load_rd = rd_req && ((state_q == IDLE) || ((state_q == READ) && last));

`ifdef FB_WR_COALESCE_EN
  logic [FIFO_LOG2-1:0] newest;
  assign newest = wptr_q - FIFO_LOG2'(1);
  // Newest entry is only mergeable if it is not leaving the FIFO this cycle.
  assign match  = !empty && (fifo_mem[newest].addr == wr_addr) &&
                  !(pop && (level_q == (FIFO_LOG2+1)'(1)));
`else
  assign match  = 1'b0;
`endif

  assign wr_ready   = !full || match;
  assign push       = wr_valid && wr_ready && !match;
  assign upd        = wr_valid && match;
  assign fifo_level = level_q;

  assign mem_adr    = {{(26-ADDR_W){1'b0}}, addr_q};
  assign mem_db_out = {8'h00, data_q};
  assign ram_adv_n  = 1'b0;
  assign ram_ub_n   = 1'b1;
  assign ram_lb_n   = ram_cs_n;

  // State register and access counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= ((state_q == READ || state_q == WRITE) && !last) ? cnt_q + CNT_W'(1) : '0;
    end
  end

  // Next state and RAM strobes
  always_comb begin
    state_d   = state_q;
    ram_cs_n  = 1'b1;
    mem_oe_n  = 1'b1;
    mem_we_n  = 1'b1;
    mem_db_oe = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_req)               state_d = READ;
        else if (blank && !empty) state_d = WRITE;
      end
      READ: begin
        ram_cs_n = 1'b0;
        mem_oe_n = 1'b0;
        if (last) state_d = rd_req ? READ : IDLE;
      end
      WRITE: begin
        ram_cs_n  = 1'b0;
        mem_db_oe = 1'b1;
        // WE pulse sits inside the access so addr/data have setup and hold.
        mem_we_n  = !((cnt_q != '0) && !last);
        if (last) state_d = TURN;
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO storage (no reset needed; level/pointers define validity)
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_q] <= '{addr: wr_addr, data: wr_data};
`ifdef FB_WR_COALESCE_EN
    else if (upd) fifo_mem[newest].data <= wr_data;
`endif
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + FIFO_LOG2'(1);
      if (pop)  rptr_q <= rptr_q + FIFO_LOG2'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + (FIFO_LOG2+1)'(1);
        2'b01:   level_q <= level_q - (FIFO_LOG2+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Access address/data latches, pixel capture and sticky errors
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q      <= '0;
      data_q      <= '0;
      pixel       <= '0;
      pixel_valid <= 1'b0;
      err_ovf     <= 1'b0;
      err_rdmiss  <= 1'b0;
    end else begin
      if (load_rd) addr_q <= rd_addr;
      else if (pop) begin
        addr_q <= fifo_mem[rptr_q].addr;
        data_q <= fifo_mem[rptr_q].data;
      end
      pixel_valid <= (state_q == READ) && last;
      if ((state_q == READ) && last) pixel <= mem_db_in[7:0];
      if (wr_valid && !wr_ready) err_ovf <= 1'b1;
      if (rd_req && !load_rd)    err_rdmiss <= 1'b1;
    end
  end

  // upd is only consumed when coalescing is built in
  logic unused_upd;
  assign unused_upd = upd;
endmodule

// File: tb/tb_fb_sram_port.sv
// Directed bench for fb_sram_port: reset, read latency, back-to-back reads,
// blank-gated draining, overflow, coalescing and reset during a write.
module tb_fb_sram_port;
  localparam int ADDR_W = 15;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              blank;
  logic [7:0]        pixel;
  logic              pixel_valid;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [3:0]        fifo_level;
  logic              err_ovf, err_rdmiss;
  logic [25:0]       mem_adr;
  logic [15:0]       mem_db_out;
  logic              mem_db_oe;
  logic [15:0]       mem_db_in;
  logic              mem_oe_n, mem_we_n, ram_cs_n, ram_lb_n, ram_ub_n, ram_adv_n;

  fb_sram_port dut (
    .clk(clk), .reset_n(reset_n), .rd_req(rd_req), .rd_addr(rd_addr), .blank(blank),
    .pixel(pixel), .pixel_valid(pixel_valid), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .fifo_level(fifo_level), .err_ovf(err_ovf),
    .err_rdmiss(err_rdmiss), .mem_adr(mem_adr), .mem_db_out(mem_db_out),
    .mem_db_oe(mem_db_oe), .mem_db_in(mem_db_in), .mem_oe_n(mem_oe_n),
    .mem_we_n(mem_we_n), .ram_cs_n(ram_cs_n), .ram_lb_n(ram_lb_n),
    .ram_ub_n(ram_ub_n), .ram_adv_n(ram_adv_n)
  );

  always #5 clk = ~clk;

  // Power-on RAM content; 0x1234 holds the known byte A5.
  function automatic logic [7:0] pat(input logic [14:0] a);
    return (a == 15'h1234) ? 8'hA5 : (a[7:0] ^ 8'h3C);
  endfunction

  // PSRAM model: write on clock edges where WE and CS are low; async read.
  logic [7:0] ram [0:32767];
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 32768; i++) ram[i] <= pat(15'(i));
    end else if (!mem_we_n && !ram_cs_n) begin
      ram[mem_adr[14:0]] <= mem_db_out[7:0];
    end
  end
  assign mem_db_in = {8'h00, ram[mem_adr[14:0]]};

  // Bus activity counters and protocol violations
  int n_we = 0, n_cs = 0, n_pv = 0, viol = 0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (!mem_we_n) n_we <= n_we + 1;
      if (!ram_cs_n) n_cs <= n_cs + 1;
      if (pixel_valid) n_pv <= n_pv + 1;
      if ((!mem_we_n && (!mem_db_oe || !mem_oe_n)) || (mem_adr[25:15] != 0) ||
          (ram_lb_n != ram_cs_n) || !ram_ub_n || ram_adv_n)
        viol <= viol + 1;
    end
  end

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [14:0] a, input logic [7:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_valid = 1'b0;
  endtask

  typedef struct { logic [14:0] addr; logic [7:0] exp; } rd_vec_t;
  typedef struct { logic [14:0] addr; logic [7:0] data; } wr_vec_t;
  rd_vec_t rtab [6];
  wr_vec_t wtab [3];

  initial begin
    int we0, cs0, pv0, t3_pv, t3_gap, t3_bad;
    rtab[0] = '{15'h1234, 8'hA5};
    rtab[1] = '{15'h0000, 8'h3C};
    rtab[2] = '{15'h00FF, 8'hC3};
    rtab[3] = '{15'h7FFF, 8'hC3};
    rtab[4] = '{15'h0055, 8'h69};
    rtab[5] = '{15'h4AA0, 8'h9C};
    wtab[0] = '{15'h0200, 8'h11};
    wtab[1] = '{15'h0201, 8'h22};
    wtab[2] = '{15'h0202, 8'h33};

    reset_n = 1'b0; rd_req = 1'b0; rd_addr = '0; blank = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    tick(); tick();
    chk("rst_strobes", {mem_oe_n, mem_we_n, ram_cs_n, ram_lb_n, ram_ub_n, ram_adv_n}, 6'b111110);
    chk("rst_db_oe", mem_db_oe, 0);
    chk("rst_adr", mem_adr, 0);
    chk("rst_pixel", {pixel, pixel_valid}, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_errs", {err_ovf, err_rdmiss}, 0);
    reset_n = 1'b1;
    tick();

    // Single read: address on the bus for ACC_CYC cycles, pixel one cycle after.
    rd_req = 1'b1; rd_addr = 15'h1234;
    tick();
    rd_req = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("t2_adr", mem_adr, 26'h1234);
      chk("t2_strobes", {mem_oe_n, ram_cs_n, mem_we_n, pixel_valid}, 4'b0010);
      tick();
    end
    chk("t2_pv", pixel_valid, 1);
    chk("t2_pixel", pixel, 8'hA5);
    tick();
    chk("t2_pv_off", pixel_valid, 0);
    chk("t2_hold", pixel, 8'hA5);

    // Read vector table
    for (int v = 0; v < 6; v++) begin
      rd_req = 1'b1; rd_addr = rtab[v].addr;
      tick();
      rd_req = 1'b0;
      tick(); tick(); tick(); tick();
      chk("tab_pv", pixel_valid, 1);
      chk("tab_pixel", pixel, rtab[v].exp);
    end
    tick();

    // Back-to-back reads: new request on each final edge, no idle gap.
    t3_pv = 0; t3_gap = 0; t3_bad = 0;
    for (int i = 0; i <= 160; i++) begin
      rd_req = (i < 160); rd_addr = 15'(i);
      tick();
      rd_req = 1'b0;
      if (i > 0) begin
        t3_pv += int'(pixel_valid);
        if (pixel !== pat(15'(i - 1))) t3_bad++;
      end
      if (i < 160) begin
        if (mem_oe_n) t3_gap++;
        for (int c = 0; c < 3; c++) begin
          tick();
          if (mem_oe_n) t3_gap++;
          if (pixel_valid) t3_bad++;
        end
      end
    end
    chk("t3_pv_count", t3_pv, 160);
    chk("t3_gap", t3_gap, 0);
    chk("t3_pixels", t3_bad, 0);
    chk("t3_rdmiss", err_rdmiss, 0);
    tick();

    // Writes queue while active, drain during blank.
    we0 = n_we;
    foreach (wtab[k]) wr(wtab[k].addr, wtab[k].data);
    chk("t4_level", fifo_level, 3);
    tick(); tick();
    chk("t4_level_hold", fifo_level, 3);
    chk("t4_no_we", n_we - we0, 0);
    we0 = n_we; cs0 = n_cs;
    blank = 1'b1;
    repeat (20) tick();
    blank = 1'b0;
    chk("t4_level_empty", fifo_level, 0);
    chk("t4_we_cycles", n_we - we0, 6);
    chk("t4_cs_cycles", n_cs - cs0, 12);
    foreach (wtab[k]) chk("t4_ram", ram[wtab[k].addr], wtab[k].data);

    // Overflow: 9 writes into an 8-deep FIFO.
    for (int i = 0; i < 9; i++) begin
      chk("t5_wr_ready", wr_ready, (i < 8) ? 1 : 0);
      if (i == 8) chk("t5_ovf_before", err_ovf, 0);
      wr(15'h0300 + 15'(i), 8'h80 + 8'(i));
    end
    chk("t5_level", fifo_level, 8);
    chk("t5_ovf", err_ovf, 1);
    blank = 1'b1;
    repeat (55) tick();
    blank = 1'b0;
    chk("t5_level_empty", fifo_level, 0);
    for (int i = 0; i < 8; i++) chk("t5_ram", ram[15'h0300 + 15'(i)], 8'h80 + 8'(i));
    chk("t5_dropped", ram[15'h0308], 8'h34);

    // Same-address writes, then a read request landing inside a WRITE.
    pv0 = n_pv;
    wr(15'h0010, 8'h11);
    wr(15'h0010, 8'h22);
`ifdef FB_WR_COALESCE_EN
    chk("t6_level", fifo_level, 1);
`else
    chk("t6_level", fifo_level, 2);
`endif
    blank = 1'b1;
    tick();
    rd_req = 1'b1; rd_addr = 15'h0000;
    tick();
    rd_req = 1'b0;
    chk("t6_rdmiss", err_rdmiss, 1);
    repeat (16) tick();
    blank = 1'b0;
    chk("t6_level_empty", fifo_level, 0);
    chk("t6_ram", ram[15'h0010], 8'h22);
    chk("t6_no_pixel", n_pv - pv0, 0);
    chk("t6_pixel_hold", pixel, 8'hA3);
    chk("bus_violations", viol, 0);

    // Reset asserted in the middle of a write.
    wr(15'h0040, 8'h77);
    wr(15'h0041, 8'h88);
    blank = 1'b1;
    tick(); tick();
    chk("t1_we_active", mem_we_n, 0);
    reset_n = 1'b0;
    tick();
    chk("t1_strobes", {mem_oe_n, mem_we_n, ram_cs_n, ram_lb_n, ram_ub_n}, 5'b11111);
    chk("t1_db_oe", mem_db_oe, 0);
    chk("t1_level", fifo_level, 0);
    chk("t1_errs", {err_ovf, err_rdmiss}, 0);
    chk("t1_adr", mem_adr, 0);
    reset_n = 1'b1; blank = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
